// File: rtl/decode_pipe_stage_if.sv
// Signal bundle for decode_pipe_stage: pipeline controls, fetch fields,
// bypass sources, the D register view and the combinational decode results.
interface decode_pipe_stage_if;
    logic        D_stall;
    logic        D_bubble;
    logic [3:0]  f_stat;
    logic [3:0]  f_icode;
    logic [3:0]  f_ifun;
    logic [3:0]  f_rA;
    logic [3:0]  f_rB;
    logic [63:0] f_valC;
    logic [63:0] f_valP;
    logic [3:0]  e_dstE;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;
    logic [63:0] e_valE;
    logic [63:0] M_valE;
    logic [63:0] m_valM;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [3:0]  D_stat;
    logic [3:0]  D_icode;
    logic [3:0]  D_ifun;
    logic [3:0]  D_rA;
    logic [3:0]  D_rB;
    logic [63:0] D_valC;
    logic [63:0] D_valP;
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    logic [3:0]  d_dstE;
    logic [3:0]  d_dstM;
    logic [63:0] d_valA;
    logic [63:0] d_valB;

    modport slave (
        input  D_stall, D_bubble,
        input  f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
        input  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM,
        input  e_valE, M_valE, m_valM, W_valE, W_valM,
        output D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
        output d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB
    );

    modport master (
        output D_stall, D_bubble,
        output f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
        output e_dstE, M_dstE, M_dstM, W_dstE, W_dstM,
        output e_valE, M_valE, m_valM, W_valE, W_valM,
        input  D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
        input  d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB
    );
endinterface

// File: rtl/decode_pipe_stage.sv
// Y86-64 decode stage: D pipeline register, 15x64 register file and operand
// selection. Define DECODE_FWD_EN to build in the e/M/W bypass network.
module decode_pipe_stage (
    input logic                 clk,
    input logic                 reset,
    decode_pipe_stage_if.slave  bus
);
    localparam logic [3:0] REG_NONE    = 4'hf;
    localparam logic [3:0] STAT_BUBBLE = 4'b1000;
    localparam logic [3:0] ICODE_NOP   = 4'h1;

    logic [3:0]  stat_q, stat_d, icode_q, icode_d, ifun_q, ifun_d;
    logic [3:0]  ra_q, ra_d, rb_q, rb_d;
    logic [63:0] valc_q, valc_d, valp_q, valp_d;
    logic [63:0] rf_q [0:14];
    logic [63:0] rf_d [0:14];
    logic [3:0]  src_a_s, src_b_s, dst_e_s, dst_m_s;
    logic [63:0] rf_a_s, rf_b_s, val_a_s, val_b_s;

    // D register next state: stall beats bubble, bubble beats capture.
    always_comb begin
        stat_d  = stat_q;
        icode_d = icode_q;
        ifun_d  = ifun_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        valc_d  = valc_q;
        valp_d  = valp_q;
        if (bus.D_stall) begin
            stat_d = stat_q;
        end else if (bus.D_bubble) begin
            stat_d  = STAT_BUBBLE;
            icode_d = ICODE_NOP;
            ifun_d  = 4'h0;
            ra_d    = REG_NONE;
            rb_d    = REG_NONE;
            valc_d  = 64'd0;
            valp_d  = 64'd0;
        end else begin
            stat_d  = bus.f_stat;
            icode_d = bus.f_icode;
            ifun_d  = bus.f_ifun;
            ra_d    = bus.f_rA;
            rb_d    = bus.f_rB;
            valc_d  = bus.f_valC;
            valp_d  = bus.f_valP;
        end
    end

    // D register state; reset loads the bubble pattern.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_q  <= STAT_BUBBLE;
            icode_q <= ICODE_NOP;
            ifun_q  <= 4'h0;
            ra_q    <= REG_NONE;
            rb_q    <= REG_NONE;
            valc_q  <= 64'd0;
            valp_q  <= 64'd0;
        end else begin
            stat_q  <= stat_d;
            icode_q <= icode_d;
            ifun_q  <= ifun_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            valc_q  <= valc_d;
            valp_q  <= valp_d;
        end
    end

    // Register file writeback; the M port wins when both ports target one ID.
    always_comb begin
        for (int i = 0; i < 15; i++) begin
            if (bus.W_dstM == 4'(i)) begin
                rf_d[i] = bus.W_valM;
            end else if (bus.W_dstE == 4'(i)) begin
                rf_d[i] = bus.W_valE;
            end else begin
                rf_d[i] = rf_q[i];
            end
        end
    end

    // Register file storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) begin
                rf_q[i] <= 64'd0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    // Source/destination register selection by instruction code.
    always_comb begin
        case (icode_q)
            4'h2, 4'h4, 4'h6, 4'hA: src_a_s = ra_q;
            4'h9, 4'hB:             src_a_s = 4'h4;
            default:                src_a_s = REG_NONE;
        endcase
        case (icode_q)
            4'h4, 4'h5, 4'h6:       src_b_s = rb_q;
            4'h8, 4'h9, 4'hA, 4'hB: src_b_s = 4'h4;
            default:                src_b_s = REG_NONE;
        endcase
        case (icode_q)
            4'h2, 4'h3, 4'h6:       dst_e_s = rb_q;
            4'h8, 4'h9, 4'hA, 4'hB: dst_e_s = 4'h4;
            default:                dst_e_s = REG_NONE;
        endcase
        case (icode_q)
            4'h5, 4'hB:             dst_m_s = ra_q;
            default:                dst_m_s = REG_NONE;
        endcase
    end

    // Combinational reads return the pre-write contents during a write cycle.
    always_comb begin
        if (src_a_s != REG_NONE) begin
            rf_a_s = rf_q[src_a_s];
        end else begin
            rf_a_s = 64'd0;
        end
        if (src_b_s != REG_NONE) begin
            rf_b_s = rf_q[src_b_s];
        end else begin
            rf_b_s = 64'd0;
        end
    end

`ifdef DECODE_FWD_EN
    // Operand A: return address first, then youngest bypass source.
    always_comb begin
        if ((icode_q == 4'h7) || (icode_q == 4'h8)) begin
            val_a_s = valp_q;
        end else if (src_a_s == REG_NONE) begin
            val_a_s = rf_a_s;
        end else if (src_a_s == bus.e_dstE) begin
            val_a_s = bus.e_valE;
        end else if (src_a_s == bus.M_dstM) begin
            val_a_s = bus.m_valM;
        end else if (src_a_s == bus.M_dstE) begin
            val_a_s = bus.M_valE;
        end else if (src_a_s == bus.W_dstM) begin
            val_a_s = bus.W_valM;
        end else if (src_a_s == bus.W_dstE) begin
            val_a_s = bus.W_valE;
        end else begin
            val_a_s = rf_a_s;
        end
    end

    // Operand B: same bypass order without the return-address term.
    always_comb begin
        if (src_b_s == REG_NONE) begin
            val_b_s = rf_b_s;
        end else if (src_b_s == bus.e_dstE) begin
            val_b_s = bus.e_valE;
        end else if (src_b_s == bus.M_dstM) begin
            val_b_s = bus.m_valM;
        end else if (src_b_s == bus.M_dstE) begin
            val_b_s = bus.M_valE;
        end else if (src_b_s == bus.W_dstM) begin
            val_b_s = bus.W_valM;
        end else if (src_b_s == bus.W_dstE) begin
            val_b_s = bus.W_valE;
        end else begin
            val_b_s = rf_b_s;
        end
    end
`else
    // Without bypassing, hazards are covered by stalls from the control unit.
    logic unused_bypass_s;
    assign unused_bypass_s = ^{bus.e_dstE, bus.e_valE, bus.M_dstE, bus.M_valE,
                               bus.M_dstM, bus.m_valM};

    // Operand selection straight from the register file.
    always_comb begin
        if ((icode_q == 4'h7) || (icode_q == 4'h8)) begin
            val_a_s = valp_q;
        end else begin
            val_a_s = rf_a_s;
        end
        val_b_s = rf_b_s;
    end
`endif

    assign bus.D_stat  = stat_q;
    assign bus.D_icode = icode_q;
    assign bus.D_ifun  = ifun_q;
    assign bus.D_rA    = ra_q;
    assign bus.D_rB    = rb_q;
    assign bus.D_valC  = valc_q;
    assign bus.D_valP  = valp_q;
    assign bus.d_srcA  = src_a_s;
    assign bus.d_srcB  = src_b_s;
    assign bus.d_dstE  = dst_e_s;
    assign bus.d_dstM  = dst_m_s;
    assign bus.d_valA  = val_a_s;
    assign bus.d_valB  = val_b_s;
endmodule
